pipelined_rounding_adder_tree: RTL and testbench

Streaming, fully pipelined N-input adder with valid/ready handshake, per-sample selectable rounding and output saturation. It is the next generation of the team's multi-input rounding adder: registered adder-tree levels instead of a single-cycle sum, backpressure support, and three rounding modes. It sits between parallel filter/correlator taps and downstream stream consumers.

---
 rtl/pipelined_rounding_adder_tree_pkg.sv | 19 +
 rtl/pipelined_rounding_adder_tree_if.sv | 34 +++
 rtl/pipelined_rounding_adder_tree_level.sv | 35 +++
 rtl/pipelined_rounding_adder_tree.sv | 159 +++++++++++++++
 tb/tb_pipelined_rounding_adder_tree.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_rounding_adder_tree_pkg.sv
// Shared types and sizing helpers for the pipelined rounding adder tree.
// Rounding-mode encoding plus the sum-width rule used by the tree and round stage.
package adder_tree_pkg;

  localparam int MODE_W = 2;

  // Encoding 2'd3 is not named: it falls through to truncation like RND_TRUNC.
  typedef enum logic [MODE_W-1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_HALF_EVEN = 2'd2
  } round_mode_e;

  // Width that holds the sum of num operands of the given width without overflow.
  function automatic int sum_width(input int num, input int width);
    return width + $clog2(num);
  endfunction

endpackage

// File: rtl/pipelined_rounding_adder_tree_if.sv
// Stream interface of the rounding adder tree: operand input side, result output
// side and the saturation sticky flag controls.
interface pipelined_rounding_adder_tree_if #(
  parameter int NUM_INPUT = 4,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 8
);
  import adder_tree_pkg::*;

  // Handshake: a transfer happens on a rising clk edge where valid && ready.
  // The source holds data stable while valid is high and ready is low; valid never
  // waits on ready. in_ready is a one-level function of out_valid/out_ready.
  logic                                in_valid;
  logic                                in_ready;
  logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  din;
  logic [MODE_W-1:0]                   round_mode;
  logic                                out_valid;
  logic                                out_ready;
  logic [WIDTH_OUT-1:0]                dout;
  logic                                sat;
  logic                                sat_sticky;
  logic                                sat_clr;

  modport master (
    output in_valid, din, round_mode, out_ready, sat_clr,
    input  in_ready, out_valid, dout, sat, sat_sticky
  );

  modport slave (
    input  in_valid, din, round_mode, out_ready, sat_clr,
    output in_ready, out_valid, dout, sat, sat_sticky
  );

endinterface

// File: rtl/pipelined_rounding_adder_tree_level.sv
// One registered pairwise-add level of the adder tree. Carries a valid bit and a
// side-band field (the rounding mode) alongside the partial sums.
module adder_tree_level #(
  parameter int N_IN   = 4,
  parameter int W      = 10,
  parameter int SIDE_W = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [N_IN-1:0][W-1:0]      din,
  input  logic [SIDE_W-1:0]           side_in,
  output logic                        out_valid,
  output logic [N_IN/2-1:0][W-1:0]    dout,
  output logic [SIDE_W-1:0]           side_out
);

  localparam int N_OUT = N_IN / 2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      side_out  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      side_out  <= side_in;
      for (int i = 0; i < N_OUT; i++) begin
        dout[i] <= din[2*i] + din[2*i+1];
      end
    end
  end

endmodule

// File: rtl/pipelined_rounding_adder_tree.sv
// Streaming N-input adder: registered tree levels, a rounding stage and a
// saturating output register, all held together by one global stall enable.
module pipelined_rounding_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int NUM_INPUT = 4,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 8,
  parameter int SHIFT     = 2,
  parameter int IS_SIGNED = 1
) (
  input logic                          clk,
  input logic                          rst,
  pipelined_rounding_adder_tree_if.slave bus
);

  localparam int LEVELS = $clog2(NUM_INPUT);
  localparam int NP     = 1 << LEVELS;
  localparam int WS     = sum_width(NUM_INPUT, WIDTH_IN);
  localparam int SH1    = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int SH_IDX = (SHIFT < WS) ? SHIFT : WS - 1;
  localparam int CW     = (WIDTH_OUT > WS + 1) ? WIDTH_OUT : WS + 1;

  localparam logic [WS:0]          HALF      = (SHIFT > 0) ? ((WS+1)'(1) << SH1) : '0;
  localparam logic [WS:0]          ONE       = {{WS{1'b0}}, 1'b1};
  localparam logic [WIDTH_OUT-1:0] SAT_MAX_S = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  localparam logic [WIDTH_OUT-1:0] SAT_MIN_S = {1'b1, {(WIDTH_OUT-1){1'b0}}};
  localparam logic [WIDTH_OUT-1:0] SAT_MAX_U = '1;

  logic en;
  assign en           = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = en;

  // Operands widened to the full sum width so every tree level adds at WS bits.
  logic [NP-1:0][WS-1:0] ext_ops;
  always_comb begin
    ext_ops = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      if (IS_SIGNED != 0) ext_ops[i] = WS'($signed(bus.din[i]));
      else                ext_ops[i] = WS'(bus.din[i]);
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = NP >> l;
    logic [NI-1:0][WS-1:0]   d_in;
    logic                    v_in;
    logic [MODE_W-1:0]       m_in;
    logic [NI/2-1:0][WS-1:0] d_out;
    logic                    v_out;
    logic [MODE_W-1:0]       m_out;

    if (l == 0) begin : g_first
      assign d_in = ext_ops;
      assign v_in = bus.in_valid;
      assign m_in = bus.round_mode;
    end else begin : g_next
      assign d_in = g_lvl[l-1].d_out;
      assign v_in = g_lvl[l-1].v_out;
      assign m_in = g_lvl[l-1].m_out;
    end

    adder_tree_level #(.N_IN(NI), .W(WS), .SIDE_W(MODE_W)) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (v_in),
      .din       (d_in),
      .side_in   (m_in),
      .out_valid (v_out),
      .dout      (d_out),
      .side_out  (m_out)
    );
  end

  logic [WS-1:0]     tree_sum;
  logic              tree_valid;
  logic [MODE_W-1:0] tree_mode;
  assign tree_sum   = g_lvl[LEVELS-1].d_out[0];
  assign tree_valid = g_lvl[LEVELS-1].v_out;
  assign tree_mode  = g_lvl[LEVELS-1].m_out;

  // Round stage: one bit wider than the sum so the rounding increment never wraps.
  logic [WS:0] s_ext, addend, rnd_sum, rnd_n, rnd_q;
  logic        rnd_valid;

  always_comb begin
    addend = '0;
    if (IS_SIGNED != 0) s_ext = {tree_sum[WS-1], tree_sum};
    else                s_ext = {1'b0, tree_sum};
    if (SHIFT > 0) begin
      case (round_mode_e'(tree_mode))
        RND_HALF_UP:   addend = HALF;
        RND_HALF_EVEN: addend = HALF - ONE + {{WS{1'b0}}, tree_sum[SH_IDX]};
        default:       addend = '0;
      endcase
    end
    rnd_sum = s_ext + addend;
    if (IS_SIGNED != 0) rnd_n = $signed(rnd_sum) >>> SHIFT;
    else                rnd_n = rnd_sum >> SHIFT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_valid <= 1'b0;
      rnd_q     <= '0;
    end else if (en) begin
      rnd_valid <= tree_valid;
      rnd_q     <= rnd_n;
    end
  end

  // Saturate: the result fits when every bit above the output field matches its sign.
  logic [CW-1:0]        r_wide;
  logic [WIDTH_OUT-1:0] dout_n;
  logic                 ovf;

  always_comb begin
    ovf = 1'b0;
    if (IS_SIGNED != 0) r_wide = CW'($signed(rnd_q));
    else                r_wide = CW'(rnd_q);
    dout_n = r_wide[WIDTH_OUT-1:0];
    if (IS_SIGNED != 0) begin
      for (int b = WIDTH_OUT - 1; b < CW - 1; b++) begin
        if (r_wide[b] != r_wide[CW-1]) ovf = 1'b1;
      end
      if (ovf) dout_n = r_wide[CW-1] ? SAT_MIN_S : SAT_MAX_S;
    end else begin
      for (int b = WIDTH_OUT; b < CW; b++) begin
        if (r_wide[b]) ovf = 1'b1;
      end
      if (ovf) dout_n = SAT_MAX_U;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.dout      <= '0;
      bus.sat       <= 1'b0;
    end else if (en) begin
      bus.out_valid <= rnd_valid;
      bus.dout      <= dout_n;
      bus.sat       <= ovf;
    end
  end

  // A clipped result leaving the block outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sat_sticky <= 1'b0;
    end else if (bus.out_valid && bus.out_ready && bus.sat) begin
      bus.sat_sticky <= 1'b1;
    end else if (bus.sat_clr) begin
      bus.sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_rounding_adder_tree.sv
// Bench for pipelined_rounding_adder_tree: a default instance driven through a
// scoreboard, plus integer-mode signed and unsigned instances for saturation.
module tb_pipelined_rounding_adder_tree;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipelined_rounding_adder_tree_if #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8)) ifa ();
  pipelined_rounding_adder_tree_if #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8)) ifb ();
  pipelined_rounding_adder_tree_if #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8)) ifc ();

  pipelined_rounding_adder_tree #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8), .SHIFT(2), .IS_SIGNED(1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  pipelined_rounding_adder_tree #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8), .SHIFT(0), .IS_SIGNED(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  pipelined_rounding_adder_tree #(.NUM_INPUT(4), .WIDTH_IN(8), .WIDTH_OUT(8), .SHIFT(0), .IS_SIGNED(0))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  int n_checks = 0;
  int n_err    = 0;

  logic [8:0]  exp_q[$];
  int          acc_cyc_q[$];
  logic [31:0] stim_ops_q[$];
  logic [1:0]  stim_mode_q[$];
  int          cyc      = 0;
  int          last_lat = -1;
  logic        b_sticky_exp = 1'b0;
  logic        c_sticky_exp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Reference: exact sum, real-valued division, then the rounding rule and clamp.
  function automatic logic [8:0] model(input logic [31:0] ops, input logic [1:0] mode,
                                       input int sh, input bit sgn);
    int  s = 0;
    int  r, lo, hi;
    real x, fl;
    logic clip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sgn) s += int'($signed(ops[8*i +: 8]));
      else     s += int'(ops[8*i +: 8]);
    end
    x  = real'(s) / real'(1 << sh);
    fl = $floor(x);
    case (mode)
      2'd1: r = int'($floor(x + 0.5));
      2'd2: begin
        if (x - fl > 0.5)      r = int'(fl) + 1;
        else if (x - fl < 0.5) r = int'(fl);
        else                   r = (int'(fl) % 2 == 0) ? int'(fl) : int'(fl) + 1;
      end
      default: r = int'(fl);
    endcase
    lo = sgn ? -128 : 0;
    hi = sgn ? 127 : 255;
    if (r > hi) begin r = hi; clip = 1'b1; end
    if (r < lo) begin r = lo; clip = 1'b1; end
    return {clip, r[7:0]};
  endfunction

  task automatic push_a(input logic [31:0] ops, input logic [1:0] mode);
    stim_ops_q.push_back(ops);
    stim_mode_q.push_back(mode);
  endtask

  // One cycle on instance A: drive, sample mid-cycle, score, advance past the edge.
  task automatic a_cycle(input bit rdy);
    ifa.out_ready = rdy;
    if (stim_ops_q.size() > 0) begin
      ifa.in_valid   = 1'b1;
      ifa.din        = stim_ops_q[0];
      ifa.round_mode = stim_mode_q[0];
    end else begin
      ifa.in_valid   = 1'b0;
      ifa.din        = $urandom;
      ifa.round_mode = 2'($urandom_range(0, 3));
    end
    #3;
    if (exp_q.size() == 0) begin
      chk("a_no_stray_out", {31'd0, ifa.out_valid}, 32'd0);
    end else if (ifa.out_valid) begin
      chk("a_dout", {24'd0, ifa.dout}, {24'd0, exp_q[0][7:0]});
      chk("a_sat", {31'd0, ifa.sat}, {31'd0, exp_q[0][8]});
      if (rdy) begin
        last_lat = cyc - acc_cyc_q[0];
        void'(exp_q.pop_front());
        void'(acc_cyc_q.pop_front());
      end
    end
    if (ifa.out_valid && !rdy) chk("a_in_ready_stall", {31'd0, ifa.in_ready}, 32'd0);
    if (rdy)                   chk("a_in_ready_free", {31'd0, ifa.in_ready}, 32'd1);
    if (ifa.in_valid && ifa.in_ready) begin
      exp_q.push_back(model(stim_ops_q[0], stim_mode_q[0], 2, 1'b1));
      acc_cyc_q.push_back(cyc);
      void'(stim_ops_q.pop_front());
      void'(stim_mode_q.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // pat 0: always ready; 1: ready low for cycles 6..8; 2: random ready.
  task automatic drain_a(input int pat, input int budget);
    int  n = 0;
    bit  rdy;
    while ((stim_ops_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      if (pat == 0)      rdy = 1'b1;
      else if (pat == 1) rdy = !(n >= 6 && n <= 8);
      else               rdy = ($urandom_range(0, 3) != 0);
      a_cycle(rdy);
      n++;
    end
    chk("a_drain_done", 32'(exp_q.size() + stim_ops_q.size()), 32'd0);
  endtask

  task automatic bc_sample(input logic [31:0] ob, input logic [31:0] oc, input bit clr);
    logic [8:0] eb, ec;
    logic [1:0] m;
    int n;
    m  = 2'($urandom_range(0, 3));
    eb = model(ob, m, 0, 1'b1);
    ec = model(oc, m, 0, 1'b0);
    ifb.in_valid = 1'b1; ifb.din = ob; ifb.round_mode = m;
    ifc.in_valid = 1'b1; ifc.din = oc; ifc.round_mode = m;
    @(posedge clk); #1;
    ifb.in_valid = 1'b0;
    ifc.in_valid = 1'b0;
    n = 1;
    while (!ifb.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bc_latency", 32'(n), 32'd4);
    chk("c_out_valid", {31'd0, ifc.out_valid}, 32'd1);
    chk("b_dout", {24'd0, ifb.dout}, {24'd0, eb[7:0]});
    chk("b_sat", {31'd0, ifb.sat}, {31'd0, eb[8]});
    chk("c_dout", {24'd0, ifc.dout}, {24'd0, ec[7:0]});
    chk("c_sat", {31'd0, ifc.sat}, {31'd0, ec[8]});
    ifb.sat_clr = clr;
    ifc.sat_clr = clr;
    b_sticky_exp = eb[8] ? 1'b1 : (clr ? 1'b0 : b_sticky_exp);
    c_sticky_exp = ec[8] ? 1'b1 : (clr ? 1'b0 : c_sticky_exp);
    @(posedge clk); #1;
    ifb.sat_clr = 1'b0;
    ifc.sat_clr = 1'b0;
    chk("b_sticky", {31'd0, ifb.sat_sticky}, {31'd0, b_sticky_exp});
    chk("c_sticky", {31'd0, ifc.sat_sticky}, {31'd0, c_sticky_exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rvec [3];

    // Clock/reset
    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.din = '0; ifa.round_mode = '0; ifa.out_ready = 1'b1; ifa.sat_clr = 1'b0;
    ifb.in_valid = 1'b0; ifb.din = '0; ifb.round_mode = '0; ifb.out_ready = 1'b1; ifb.sat_clr = 1'b0;
    ifc.in_valid = 1'b0; ifc.din = '0; ifc.round_mode = '0; ifc.out_ready = 1'b1; ifc.sat_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("rst_dout", {24'd0, ifa.dout}, 32'd0);
    chk("rst_sat", {31'd0, ifa.sat}, 32'd0);
    chk("rst_sticky", {31'd0, ifa.sat_sticky}, 32'd0);
    chk("rst_b_sticky", {31'd0, ifb.sat_sticky}, 32'd0);
    rst = 1'b0;

    // Basic sum and latency
    push_a(pack4(10, 20, 30, 40), 2'd0);
    drain_a(0, 50);
    chk("latency_basic", 32'(last_lat), 32'd4);

    // Rounding vectors, every mode back-to-back
    rvec[0] = pack4(1, 1, 1, 3);
    rvec[1] = pack4(1, 1, 4, 4);
    rvec[2] = pack4(-50, 30, -20, 10);
    for (int v = 0; v < 3; v++) begin
      for (int m = 0; m < 4; m++) push_a(rvec[v], 2'(m));
    end
    drain_a(0, 100);

    // Backpressure: six samples, ready low for three cycles mid-stream
    for (int i = 0; i < 6; i++) push_a($urandom, 2'($urandom_range(0, 3)));
    drain_a(1, 100);

    // Random stream with random backpressure
    for (int i = 0; i < 80; i++) push_a($urandom, 2'($urandom_range(0, 3)));
    drain_a(2, 2000);

    // Integer mode saturation and sticky flag
    bc_sample(pack4(127, 127, 127, 127), pack4(255, 255, 255, 255), 1'b0);
    bc_sample(pack4(5, 6, 7, 8), pack4(1, 2, 3, 4), 1'b0);
    ifb.sat_clr = 1'b1;
    ifc.sat_clr = 1'b1;
    @(posedge clk); #1;
    ifb.sat_clr = 1'b0;
    ifc.sat_clr = 1'b0;
    b_sticky_exp = 1'b0;
    c_sticky_exp = 1'b0;
    chk("b_sticky_cleared", {31'd0, ifb.sat_sticky}, 32'd0);
    chk("c_sticky_cleared", {31'd0, ifc.sat_sticky}, 32'd0);
    bc_sample(pack4(-128, -128, -128, -128), pack4(10, 20, 30, 40), 1'b1);
    for (int i = 0; i < 4; i++) bc_sample($urandom, $urandom, 1'(i % 2));

    // Reset with samples in flight
    for (int i = 0; i < 3; i++) push_a($urandom, 2'($urandom_range(0, 3)));
    repeat (3) a_cycle(1'b1);
    rst = 1'b1;
    ifa.in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("midrst_dout", {24'd0, ifa.dout}, 32'd0);
    chk("midrst_b_sticky", {31'd0, ifb.sat_sticky}, 32'd0);
    exp_q.delete();
    acc_cyc_q.delete();
    b_sticky_exp = 1'b0;
    c_sticky_exp = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) a_cycle(1'b1);
    chk("post_rst_b_idle", {31'd0, ifb.out_valid}, 32'd0);
    push_a(pack4(-50, 30, -20, 10), 2'd1);
    drain_a(0, 50);
    chk("latency_after_rst", 32'(last_lat), 32'd4);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
